// File: rtl/random_pkg.sv
// Shared definitions for the random generator and its stream checker: FSM states,
// LFSR taps and the next-state / range-mapping functions both sides must agree on.
package random_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StLoad,
        StCheck,
        StHalt
    } state_t;

    localparam int unsigned LFSR_WIDTH = 32;
    // Range mapping is done at a fixed internal width; data widths up to 64 bits fit.
    localparam int unsigned MAP_WIDTH = 64;
    localparam logic [LFSR_WIDTH-1:0] LFSR_TAPS = 32'h8020_0003;

    function automatic logic [LFSR_WIDTH-1:0] lfsr_next(input logic [LFSR_WIDTH-1:0] value);
        return value[0] ? ((value >> 1) ^ LFSR_TAPS) : (value >> 1);
    endfunction

    function automatic logic [MAP_WIDTH-1:0] map_to_range(
        input logic [LFSR_WIDTH-1:0] lfsr,
        input logic [MAP_WIDTH-1:0]  min,
        input logic [MAP_WIDTH:0]    span
    );
        logic [MAP_WIDTH:0] rem;
        // A zero span only exists before any valid configuration has been loaded.
        if (span == '0) begin
            return min;
        end
        rem = (MAP_WIDTH + 1)'(lfsr) % span;
        return min + MAP_WIDTH'(rem);
    endfunction

endpackage

// File: rtl/lfsr_core.sv
// Reference-sequence LFSR: loads a seed (zero replaced by 1) and steps once per advance.
module lfsr_core
    import random_pkg::*;
(
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  load,
    input  logic [LFSR_WIDTH-1:0] seed,
    input  logic                  advance,
    output logic [LFSR_WIDTH-1:0] value
);

    logic [LFSR_WIDTH-1:0] value_q, value_d;

    always_comb begin
        value_d = value_q;
        if (load) begin
            // An all-zero state would lock the LFSR forever.
            value_d = (seed == '0) ? LFSR_WIDTH'(1) : seed;
        end else if (advance) begin
            value_d = lfsr_next(value_q);
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            value_q <= LFSR_WIDTH'(1);
        end else begin
            value_q <= value_d;
        end
    end

    assign value = value_q;

endmodule

// File: rtl/random_stream_checker.sv
// Checks a stream of generator samples against a locally regenerated reference sequence,
// keeping sticky error flags and saturating sample / error counters.
module random_stream_checker
    import random_pkg::*;
#(
    parameter int unsigned WIDTH         = 32,
    parameter int unsigned COUNT_WIDTH   = 16,
    parameter int unsigned STOP_ON_ERROR = 0
) (
    input  logic                    in_clock,
    input  logic                    in_reset,
    input  logic                    in_enable,
    input  logic [WIDTH-1:0]        in_seed,
    input  logic signed [WIDTH-1:0] in_min,
    input  logic signed [WIDTH-1:0] in_max,
    input  logic                    in_valid,
    input  logic signed [WIDTH-1:0] in_data,
    output logic                    out_busy,
    output logic                    out_cfg_error,
    output logic                    out_range_error,
    output logic                    out_seq_error,
    output logic [COUNT_WIDTH-1:0]  out_sample_count,
    output logic [COUNT_WIDTH-1:0]  out_error_count
);

    state_t state_q, state_d;

    logic signed [WIDTH-1:0] min_q, min_d;
    logic signed [WIDTH-1:0] max_q, max_d;
    logic [WIDTH:0]          span_q, span_d;
    logic                    cfg_err_q, cfg_err_d;
    logic                    range_err_q, range_err_d;
    logic                    seq_err_q, seq_err_d;
    logic [COUNT_WIDTH-1:0]  sample_cnt_q, sample_cnt_d;
    logic [COUNT_WIDTH-1:0]  error_cnt_q, error_cnt_d;

    logic [LFSR_WIDTH-1:0]   lfsr_value;
    logic                    lfsr_load;
    logic                    lfsr_advance;
    logic signed [WIDTH-1:0] expected;
    logic                    cfg_bad;
    logic                    range_bad;
    logic                    seq_bad;

    function automatic logic [COUNT_WIDTH-1:0] sat_inc(input logic [COUNT_WIDTH-1:0] count);
        return (count == '1) ? count : count + 1'b1;
    endfunction

    lfsr_core u_lfsr_core (
        .clock   (in_clock),
        .reset   (in_reset),
        .load    (lfsr_load),
        .seed    (LFSR_WIDTH'(in_seed)),
        .advance (lfsr_advance),
        .value   (lfsr_value)
    );

    assign cfg_bad   = in_min > in_max;
    assign range_bad = (in_data < min_q) || (in_data > max_q);
    assign expected  = WIDTH'(map_to_range(lfsr_value, MAP_WIDTH'(min_q),
                                           (MAP_WIDTH + 1)'(span_q)));
    assign seq_bad   = in_data != expected;

    always_comb begin
        state_d      = state_q;
        min_d        = min_q;
        max_d        = max_q;
        span_d       = span_q;
        cfg_err_d    = cfg_err_q;
        range_err_d  = range_err_q;
        seq_err_d    = seq_err_q;
        sample_cnt_d = sample_cnt_q;
        error_cnt_d  = error_cnt_q;
        lfsr_load    = 1'b0;
        lfsr_advance = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (in_enable) begin
                    state_d = StLoad;
                end
            end
            StLoad: begin
                min_d  = in_min;
                max_d  = in_max;
                // Sign-extended difference is never negative once min <= max.
                span_d = {in_max[WIDTH-1], in_max} - {in_min[WIDTH-1], in_min}
                         + (WIDTH + 1)'(1);
                if (cfg_bad) begin
                    cfg_err_d = 1'b1;
                    state_d   = StIdle;
                end else begin
                    lfsr_load = 1'b1;
                    state_d   = StCheck;
                end
            end
            StCheck: begin
                if (in_valid && in_enable) begin
                    lfsr_advance = 1'b1;
                    sample_cnt_d = sat_inc(sample_cnt_q);
                    if (range_bad) begin
                        range_err_d = 1'b1;
                    end
                    if (seq_bad) begin
                        seq_err_d = 1'b1;
                    end
                    if (range_bad || seq_bad) begin
                        error_cnt_d = sat_inc(error_cnt_q);
                        if (STOP_ON_ERROR != 0) begin
                            state_d = StHalt;
                        end
                    end
                end
            end
            StHalt: begin
                state_d = StHalt;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge in_clock) begin
        if (in_reset) begin
            state_q      <= StIdle;
            min_q        <= '0;
            max_q        <= '0;
            span_q       <= '0;
            cfg_err_q    <= 1'b0;
            range_err_q  <= 1'b0;
            seq_err_q    <= 1'b0;
            sample_cnt_q <= '0;
            error_cnt_q  <= '0;
        end else begin
            state_q      <= state_d;
            min_q        <= min_d;
            max_q        <= max_d;
            span_q       <= span_d;
            cfg_err_q    <= cfg_err_d;
            range_err_q  <= range_err_d;
            seq_err_q    <= seq_err_d;
            sample_cnt_q <= sample_cnt_d;
            error_cnt_q  <= error_cnt_d;
        end
    end

    assign out_busy         = (state_q == StLoad) || (state_q == StCheck);
    assign out_cfg_error    = cfg_err_q;
    assign out_range_error  = range_err_q;
    assign out_seq_error    = seq_err_q;
    assign out_sample_count = sample_cnt_q;
    assign out_error_count  = error_cnt_q;

endmodule

// File: tb/tb_random_stream_checker.sv
// Bench for random_stream_checker: three instances (default, 4-bit counters, stop-on-error)
// share one stimulus stream; a sample-level reference model supplies expected values.
module tb_random_stream_checker;

    localparam logic [31:0] TAPS = 32'h8020_0003;

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic               en = 1'b0;
    logic        [31:0] seed = '0;
    logic signed [31:0] mn = '0;
    logic signed [31:0] mx = '0;
    logic               valid = 1'b0;
    logic signed [31:0] data = '0;

    logic        a_busy, a_cfg, a_rng, a_seq;
    logic [15:0] a_sc, a_ec;
    logic        b_busy, b_cfg, b_rng, b_seq;
    logic [3:0]  b_sc, b_ec;
    logic        c_busy, c_cfg, c_rng, c_seq;
    logic [15:0] c_sc, c_ec;

    int checks = 0;
    int errors = 0;

    // Reference model: one expected value per accepted sample.
    bit [31:0] m_lfsr;
    int        m_min, m_max;
    longint    m_span;
    int        m_sc, m_ec;
    bit        m_rng, m_seq;

    always #5 clk = ~clk;

    random_stream_checker u_dut_a (
        .in_clock(clk), .in_reset(rst), .in_enable(en), .in_seed(seed), .in_min(mn),
        .in_max(mx), .in_valid(valid), .in_data(data), .out_busy(a_busy),
        .out_cfg_error(a_cfg), .out_range_error(a_rng), .out_seq_error(a_seq),
        .out_sample_count(a_sc), .out_error_count(a_ec)
    );

    random_stream_checker #(.COUNT_WIDTH(4)) u_dut_b (
        .in_clock(clk), .in_reset(rst), .in_enable(en), .in_seed(seed), .in_min(mn),
        .in_max(mx), .in_valid(valid), .in_data(data), .out_busy(b_busy),
        .out_cfg_error(b_cfg), .out_range_error(b_rng), .out_seq_error(b_seq),
        .out_sample_count(b_sc), .out_error_count(b_ec)
    );

    random_stream_checker #(.STOP_ON_ERROR(1)) u_dut_c (
        .in_clock(clk), .in_reset(rst), .in_enable(en), .in_seed(seed), .in_min(mn),
        .in_max(mx), .in_valid(valid), .in_data(data), .out_busy(c_busy),
        .out_cfg_error(c_cfg), .out_range_error(c_rng), .out_seq_error(c_seq),
        .out_sample_count(c_sc), .out_error_count(c_ec)
    );

    task automatic chk(input string name, input longint act, input longint want);
        checks++;
        if (act != want) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, want);
        end
    endtask

    function automatic int m_expected();
        longint r;
        r = longint'(m_min) + (longint'(m_lfsr) % m_span);
        return int'(r);
    endfunction

    task automatic model_start(input int s, input int lo, input int hi);
        m_lfsr = (s == 0) ? 32'd1 : 32'(s);
        m_min  = lo;
        m_max  = hi;
        m_span = longint'(hi) - longint'(lo) + 1;
    endtask

    task automatic chk_zero(input string name);
        chk({name, " dut_a"}, {a_busy, a_cfg, a_rng, a_seq, a_sc, a_ec}, 0);
        chk({name, " dut_b"}, {b_busy, b_cfg, b_rng, b_seq, b_sc, b_ec}, 0);
        chk({name, " dut_c"}, {c_busy, c_cfg, c_rng, c_seq, c_sc, c_ec}, 0);
    endtask

    // Caller sits at a falling edge; returns at the falling edge after the reset release.
    task automatic do_reset(input string name);
        rst   = 1'b1;
        en    = 1'b0;
        valid = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk_zero({name, " in_reset"});
        rst = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk_zero({name, " after_reset"});
        m_sc  = 0;
        m_ec  = 0;
        m_rng = 1'b0;
        m_seq = 1'b0;
    endtask

    // IDLE -> LOAD -> CHECK (or back to IDLE on a bad range); valid pulses must be ignored.
    task automatic start(input int s, input int lo, input int hi);
        seed  = 32'(s);
        mn    = lo;
        mx    = hi;
        en    = 1'b1;
        valid = 1'b1;
        data  = $urandom;
        @(posedge clk);
        @(negedge clk);
        chk("load busy", a_busy, 1);
        chk("load no sample", a_sc, m_sc);
        @(posedge clk);
        @(negedge clk);
        model_start(s, lo, hi);
    endtask

    // One clock with the given inputs; the model consumes the sample when it is accepted.
    task automatic cycle(input bit v, input bit e, input int d);
        int  want;
        bit  bad_seq, bad_rng;
        valid = v;
        en    = e;
        data  = d;
        @(posedge clk);
        if (v && e) begin
            want    = m_expected();
            bad_seq = (d != want);
            bad_rng = (d < m_min) || (d > m_max);
            m_sc++;
            if (bad_seq || bad_rng) m_ec++;
            m_rng |= bad_rng;
            m_seq |= bad_seq;
            m_lfsr = m_lfsr[0] ? ((m_lfsr >> 1) ^ TAPS) : (m_lfsr >> 1);
        end
        @(negedge clk);
    endtask

    task automatic check_a(input string name);
        chk({name, " samples"}, a_sc, m_sc);
        chk({name, " errors"}, a_ec, m_ec);
        chk({name, " busy/cfg/rng/seq"}, {a_busy, a_cfg, a_rng, a_seq},
            {1'b1, 1'b0, m_rng, m_seq});
    endtask

    typedef struct {
        bit v;
        bit e;
        bit bad;
        int sc;
        int ec;
        bit rng;
        bit seq;
    } vec_t;

    vec_t tbl[11];

    initial begin
        int d;
        int lo, hi, t;

        tbl[0]  = '{1, 1, 0, 1, 0, 0, 0};
        tbl[1]  = '{1, 1, 0, 2, 0, 0, 0};
        tbl[2]  = '{1, 1, 0, 3, 0, 0, 0};
        tbl[3]  = '{1, 1, 0, 4, 0, 0, 0};
        tbl[4]  = '{1, 1, 1, 5, 1, 1, 1};
        tbl[5]  = '{1, 1, 0, 6, 1, 1, 1};
        tbl[6]  = '{1, 0, 0, 6, 1, 1, 1};
        tbl[7]  = '{1, 0, 0, 6, 1, 1, 1};
        tbl[8]  = '{0, 1, 0, 6, 1, 1, 1};
        tbl[9]  = '{1, 1, 0, 7, 1, 1, 1};
        tbl[10] = '{1, 1, 0, 8, 1, 1, 1};

        do_reset("power_on");

        // Eight clean samples.
        start(16, 0, 5);
        for (int i = 0; i < 8; i++) begin
            cycle(1'b1, 1'b1, m_expected());
            check_a($sformatf("clean[%0d]", i));
        end
        chk("clean final samples", a_sc, 8);
        chk("clean final errors", a_ec, 0);
        chk("clean final flags", {a_cfg, a_rng, a_seq}, 0);

        // Table: corrupted sample 4, a pause with valid high, an idle beat.
        do_reset("table");
        start(16, 0, 5);
        for (int i = 0; i < 11; i++) begin
            if (tbl[i].bad) d = -1;
            else if (tbl[i].v && tbl[i].e) d = m_expected();
            else d = int'($urandom);
            cycle(tbl[i].v, tbl[i].e, d);
            chk($sformatf("tbl[%0d] samples", i), a_sc, tbl[i].sc);
            chk($sformatf("tbl[%0d] errors", i), a_ec, tbl[i].ec);
            chk($sformatf("tbl[%0d] rng/seq", i), {a_rng, a_seq}, {tbl[i].rng, tbl[i].seq});
            chk($sformatf("tbl[%0d] busy", i), a_busy, 1);
        end
        chk("halt busy", c_busy, 0);
        chk("halt samples", c_sc, 5);
        chk("halt errors", c_ec, 1);
        chk("halt flags", {c_cfg, c_rng, c_seq}, 3'b011);
        chk("cw4 samples", b_sc, 8);

        // Inverted range: configuration error, nothing checked.
        do_reset("cfg");
        start(7, 5, 2);
        chk("cfg flag", a_cfg, 1);
        chk("cfg idle", a_busy, 0);
        for (int i = 0; i < 4; i++) cycle(1'b1, 1'b0, int'($urandom));
        chk("cfg samples", a_sc, 0);
        chk("cfg sticky", {a_cfg, a_rng, a_seq}, 3'b100);

        // Zero seed behaves as seed 1; a three-cycle pause with valid high.
        do_reset("seed0");
        start(0, -3, 100);
        for (int i = 0; i < 9; i++) begin
            if (i >= 3 && i < 6) cycle(1'b1, 1'b0, int'($urandom));
            else cycle(1'b1, 1'b1, m_expected());
            check_a($sformatf("seed0[%0d]", i));
        end
        chk("seed0 samples", a_sc, 6);

        // Saturation of 4-bit counters.
        do_reset("sat");
        start(12345, -1000, 1000);
        for (int i = 0; i < 20; i++) cycle(1'b1, 1'b1, m_expected());
        chk("sat cw4 samples", b_sc, 15);
        chk("sat cw4 errors", b_ec, 0);
        chk("sat cw16 samples", a_sc, 20);

        // Reset mid-stream, then the same seed restarts the sequence.
        do_reset("mid");
        start(99, 10, 40);
        for (int i = 0; i < 5; i++) cycle(1'b1, 1'b1, m_expected());
        check_a("mid before reset");
        do_reset("mid");
        start(99, 10, 40);
        cycle(1'b1, 1'b1, m_expected());
        chk("restart samples", a_sc, 1);
        chk("restart seq", a_seq, 0);

        // Randomized streams against the model.
        for (int k = 0; k < 3; k++) begin
            do_reset($sformatf("rnd%0d", k));
            if (k == 0) begin
                lo = $urandom_range(200) - 100;
                hi = lo + $urandom_range(20);
            end else if (k == 1) begin
                lo = int'($urandom);
                hi = int'($urandom);
                if (lo > hi) begin
                    t  = lo;
                    lo = hi;
                    hi = t;
                end
            end else begin
                lo = int'($urandom);
                hi = lo;
            end
            start(int'($urandom), lo, hi);
            for (int i = 0; i < 80; i++) begin
                d = m_expected();
                if ($urandom_range(99) < 10) d = d + $urandom_range(1, 3);
                cycle($urandom_range(99) < 75, $urandom_range(99) < 85, d);
                check_a($sformatf("rnd%0d[%0d]", k, i));
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/random_stream_checker.md
RANDOM_STREAM_CHECKER -- requirements
Module: random_stream_checker

Interface
REQ-001 Parameter WIDTH, default 32, data/seed/bound width.
REQ-002 Parameter COUNT_WIDTH, default 16, width of statistic counters.
REQ-003 Parameter STOP_ON_ERROR, default 0; 1 = halt checking on first mismatch.
REQ-004 in_clock  input  1  sole clock, all logic on rising edge.
REQ-005 in_reset  input  1  synchronous, active-high reset.
REQ-006 in_enable  input  1  load/run request; low = pause.
REQ-007 in_seed  input  WIDTH  seed, same value given to the generator under check.
REQ-008 in_min, in_max  input  WIDTH signed  inclusive range bounds.
REQ-009 in_valid  input  1  in_data carries one generator sample this cycle.
REQ-010 in_data  input  WIDTH signed  sample from generator out_random.
REQ-011 out_busy  output  1  high in LOAD and CHECK.
REQ-012 out_cfg_error  output  1  sticky; in_min > in_max at load.
REQ-013 out_range_error  output  1  sticky; a sample fell outside [min,max].
REQ-014 out_seq_error  output  1  sticky; a sample differed from the expected value.
REQ-015 out_sample_count, out_error_count  output  COUNT_WIDTH  samples checked / mismatching samples.

Function
REQ-016 States IDLE, LOAD, CHECK, HALT; encoding in the shared package.
REQ-017 IDLE -> LOAD when in_enable=1; LOAD lasts exactly one cycle.
REQ-018 LOAD latches seed, min and max; a zero seed is replaced by 1 (LFSR lock-up guard).
REQ-019 LOAD with in_min > in_max (signed) sets out_cfg_error and returns to IDLE; no samples are checked.
REQ-020 LOAD -> CHECK otherwise; sample, error and range flags remain unchanged.
REQ-021 Reference model: 32-bit Galois LFSR, taps constant LFSR_TAPS = 0x80200003; expected = min + (lfsr mod span), with span = max - min + 1 computed at WIDTH+1 bits unsigned.
REQ-022 In CHECK, a sample is accepted when in_valid=1 and in_enable=1; LFSR advances exactly once per accepted sample.
REQ-023 in_enable=0 in CHECK: samples ignored, LFSR and counters held, state stays CHECK.
REQ-024 Flags and counters update one cycle after the accepting edge (latency 1).
REQ-025 Range error: in_data < min or in_data > max (signed compare), independent of sequence check.
REQ-026 Sequence error: in_data != expected; out_error_count increments once per mismatching sample (range+seq in the same sample counts once).
REQ-027 Counters saturate at all-ones and do not wrap.
REQ-028 STOP_ON_ERROR=1: first mismatch -> HALT; HALT holds all outputs until reset; out_busy=0 in HALT.
REQ-029 in_valid in IDLE/LOAD/HALT is ignored.

Reset
REQ-030 in_reset=1 at any edge: state IDLE, all flags 0, both counters 0, LFSR reloaded with 1; takes priority over every other input, including mid-CHECK.
REQ-031 All outputs are 0 in the first cycle after reset deasserts.

Structure
REQ-032 Shared package random_pkg holds the state typedef, LFSR_TAPS, and the next-LFSR and map-to-range functions; the generator uses the same functions.
REQ-033 One sub-module, lfsr_core (load, advance, value), is instantiated for the reference sequence; the FSM, comparators and counters stay in the top module.

Verification
REQ-034 seed=16, min=0, max=5, enable=1; feed 8 samples from the package model -> sample_count=8, error_count=0, no flags set.
REQ-035 Same setup, sample 4 driven as -1 -> range_error=1 and seq_error=1 one cycle later, error_count=1; later correct samples still match.
REQ-036 min=5, max=2 -> cfg_error=1, state returns to IDLE, sample_count stays 0 despite in_valid pulses.
REQ-037 seed=0 -> checker matches a model seeded with 1; enable low for 3 cycles mid-stream with in_valid high -> counts frozen, resumption matches.
REQ-038 COUNT_WIDTH=4, 20 good samples -> sample_count=15; STOP_ON_ERROR=1 with a bad sample -> HALT, busy=0, counts frozen.
REQ-039 Reset asserted mid-CHECK after 5 samples -> next cycle all outputs 0; reload, same seed -> sequence restarts from the first value.
